// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with 8N1 framing, sent LSB first.
//
// Each frame is a start bit (0), eight data bits with tx_data[0] first, and a
// stop bit (1). Every bit lasts CLKS_PER_BIT cycles of clock_50M. A request is
// accepted only in IDLE. busy and tx=0 appear on the cycle after acceptance.
// On the edge that completes the stop bit, done pulses for one cycle and busy
// drops.
//
// Optional feature (macro UART_TX_PARITY_EN):
//   When the macro is defined, a PARITY bit goes between DATA and STOP. It
//   carries the even parity of the latched byte, giving an 8E1 frame of
//   11*CLKS_PER_BIT cycles. When the macro is undefined, no parity logic is
//   built.
//
// Parameters:
//   CLKS_PER_BIT  system clock cycles per bit period (217 gives 230400 baud at 50 MHz)
//   CNT_W         width of the baud counter; 2**CNT_W must exceed CLKS_PER_BIT
//
// Ports:
//   clock_50M  in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   transmit request, sampled every rising edge
//   tx_data    in   byte to send, sampled only when a request is accepted
//   busy       out  high while a frame is in progress
//   done       out  one-cycle pulse when the stop bit completes
//   tx         out  serial line, registered, idles high

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clock_50M,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Bit boundaries happen only when the baud counter wraps.
  logic bit_end;
  assign bit_end = (cnt_q == LastCnt);

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // The baud counter runs in every frame state and wraps on each bit boundary.
    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    // tx_d is the value of the line for the next cycle. This keeps tx
    // registered without adding a cycle of latency.
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d   = tx_data;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end

      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            // Shift on the same edge that puts the next bit on the line,
            // so tx always equals shift_q[0] while in DATA.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing, LSB first; the transmit counterpart of the team's uart_rx.
- Accepts one byte per start strobe from the core.
- Drives the serial tx line at a fixed baud rate derived from the 50 MHz system clock.
- Busy/done handshake lets the ONC-16 core queue the next byte.

Parameters:
CLKS_PER_BIT, 217, system clock cycles per bit period (50 MHz / 230400 baud, ~4340 ns)
CNT_W, 8, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clock_50M  input  1  system clock, all logic on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  transmit request, sampled every rising edge
tx_data  input  8  byte to send, sampled only when a request is accepted
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when the stop bit completes
tx  output  1  serial output, idle high, registered

Behaviour:
- Reset: one clock, clock_50M; reset is asynchronous, active-low n_rst. While n_rst=0: tx=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the frame is abandoned, with no done pulse.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On a rising edge with start=1: latch tx_data into the shift register, clear the baud counter and bit index, go to START.
  - busy=1 and tx=0 are visible from the cycle after acceptance (1-cycle latency).
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=shift[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - Bit index 0..7; after bit 7 go to STOP.
  - Bit order is tx_data[0] first.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle: done=1 for exactly one cycle, busy falls to 0 on the same edge, state goes to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from first tx=0 to the end of the stop bit.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit transitions occur only on the wrap.
  - No drift across a frame.
- start while busy=1: ignored, including on the done cycle. tx_data changes during a frame have no effect.
- start held high continuously: a new frame is accepted on the first IDLE cycle. The back-to-back gap is 1 idle cycle with tx=1.
- done and busy are never simultaneously asserted after the done edge; done is never asserted outside STOP completion.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 only; the parity logic is not synthesized.

Test Plan:
- Reset: assert n_rst=0 mid-frame, during the DATA bit 3 of 0xFF -> tx=1 and busy=0 immediately. After release, tx stays 1 with no done pulse.
- Single byte: start pulse with tx_data=0x55 -> next cycle busy=1, tx=0.
  - tx sequence per 217-cycle bit: 0,1,0,1,0,1,0,1,0,1.
  - done pulses once at cycle 2170 after the first tx=0; busy=0 on the same edge.
- LSB order: tx_data=0x01 -> first data bit 1, remaining 7 data bits 0, stop bit 1. Decoding with the team uart_rx yields rx_data=0x01 and ready asserted.
- Ignored request: start pulses with 0xA3 at cycle 500 of a 0x0F frame -> the frame completes as 0x0F only; no second frame; tx_data change mid-frame has no effect.
- Back-to-back: start held high with tx_data=0xC3 -> frames separated by exactly 1 idle high cycle; each frame is 2170 cycles.
- Parity (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1; 0x03 -> parity bit 0. Each frame is 2387 cycles and done pulses at its end.
